control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_pkg.sv | 53 +++++
 rtl/dec3to8.sv | 14 +
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: state encoding, opcodes and
// instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F0     = 3'd1,
    S_F1     = 3'd2,
    S_DEC    = 3'd3,
    S_T1     = 3'd4,
    S_T2     = 3'd5,
    S_T3     = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MV   = 4'd1;
  localparam logic [3:0] OP_MVI  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RX_HI  = 11;
  localparam int RX_LO  = 9;
  localparam int RY_HI  = 8;
  localparam int RY_LO  = 6;
  localparam int IMM_HI = 8;
  localparam int IMM_LO = 0;

  function automatic logic [3:0] f_op(input logic [15:0] ins);
    return ins[OP_HI:OP_LO];
  endfunction

  function automatic logic [2:0] f_rx(input logic [15:0] ins);
    return ins[RX_HI:RX_LO];
  endfunction

  function automatic logic [2:0] f_ry(input logic [15:0] ins);
    return ins[RY_HI:RY_LO];
  endfunction

  // Immediate is zero-extended to bus width.
  function automatic logic [15:0] f_imm(input logic [15:0] ins);
    return {7'b0, ins[IMM_HI:IMM_LO]};
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot register select with enable; all-zero when disabled.
module dec3to8 (
  input  logic [2:0] i_sel,
  input  logic       i_en,
  output logic [7:0] o_hot
);

  // One-hot decode gated by enable
  always_comb begin
    o_hot = '0;
    if (i_en) o_hot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for a small bus-based CPU: fetch, decode and
// execute phases driving register/ALU/PC/RAM enables from state and instr.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr,
  output logic [7:0]  rin,
  output logic [7:0]  rout,
  output logic        ctrl_out_en,
  output logic [15:0] ctrl_output,
  output logic        ain,
  output logic        addsub,
  output logic        xor_ctrl,
  output logic        gout,
  output logic        pc_in,
  output logic        pc_out,
  output logic        pc_inc,
  output logic        addr_in,
  output logic        ram_out_en,
  output logic        ram_in_en,
  output logic        ram_we,
  output logic        ir_in,
  output logic        done,
  output logic        halted,
  output logic        illegal
);

  state_t      r_state;
  state_t      w_next;
  state_t      w_after;
  logic [3:0]  w_op;
  logic [2:0]  w_rx;
  logic [2:0]  w_ry;
  logic [15:0] w_imm;
  logic        w_alu;
  logic        w_mem;
  logic        w_rin_en;
  logic [2:0]  w_rin_sel;
  logic        w_rout_en;
  logic [2:0]  w_rout_sel;

  assign w_op  = f_op(instr);
  assign w_rx  = f_rx(instr);
  assign w_ry  = f_ry(instr);
  assign w_imm = f_imm(instr);
  assign w_alu = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_XOR);
  assign w_mem = (w_op == OP_LD) || (w_op == OP_ST);

  // Where to go after the final cycle of an instruction; run is only
  // looked at here, so dropping it mid-instruction never aborts.
  assign w_after = run ? S_F0 : S_IDLE;

  // State register; reset wins over everything including HALTED
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state sequencing
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_F0;
      S_F0:     w_next = S_F1;
      S_F1:     w_next = S_DEC;
      S_DEC:    w_next = S_T1;
      S_T1: begin
        if (w_op == OP_HALT)      w_next = S_HALTED;
        else if (w_alu || w_mem)  w_next = S_T2;
        else                      w_next = w_after;
      end
      S_T2:     w_next = w_alu ? S_T3 : w_after;
      S_T3:     w_next = w_after;
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  // Moore outputs from state and instruction fields
  always_comb begin
    w_rin_en    = 1'b0;
    w_rin_sel   = '0;
    w_rout_en   = 1'b0;
    w_rout_sel  = '0;
    ctrl_out_en = 1'b0;
    ctrl_output = '0;
    ain         = 1'b0;
    addsub      = 1'b0;
    xor_ctrl    = 1'b0;
    gout        = 1'b0;
    pc_in       = 1'b0;
    pc_out      = 1'b0;
    pc_inc      = 1'b0;
    addr_in     = 1'b0;
    ram_out_en  = 1'b0;
    ram_in_en   = 1'b0;
    ram_we      = 1'b0;
    ir_in       = 1'b0;
    done        = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_F0: begin
        pc_out  = 1'b1;
        addr_in = 1'b1;
      end
      S_F1: begin
        ram_out_en = 1'b1;
        ir_in      = 1'b1;
        pc_inc     = 1'b1;
      end
      S_T1: begin
        case (w_op)
          OP_NOP: done = 1'b1;
          OP_MV: begin
            w_rout_en = 1'b1; w_rout_sel = w_ry;
            w_rin_en  = 1'b1; w_rin_sel  = w_rx;
            done      = 1'b1;
          end
          OP_MVI: begin
            ctrl_out_en = 1'b1;
            ctrl_output = w_imm;
            w_rin_en    = 1'b1; w_rin_sel = w_rx;
            done        = 1'b1;
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            w_rout_en = 1'b1; w_rout_sel = w_rx;
            ain       = 1'b1;
          end
          OP_LD, OP_ST: begin
            w_rout_en = 1'b1; w_rout_sel = w_ry;
            addr_in   = 1'b1;
          end
          OP_JMP: begin
            w_rout_en = 1'b1; w_rout_sel = w_rx;
            pc_in     = 1'b1;
            done      = 1'b1;
          end
          OP_HALT: done = 1'b1;
          default: begin
            illegal = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      S_T2: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_XOR: begin
            w_rout_en = 1'b1; w_rout_sel = w_ry;
            addsub    = (w_op == OP_SUB);
            xor_ctrl  = (w_op == OP_XOR);
          end
          OP_LD: begin
            ram_out_en = 1'b1;
            w_rin_en   = 1'b1; w_rin_sel = w_rx;
            done       = 1'b1;
          end
          OP_ST: begin
            w_rout_en = 1'b1; w_rout_sel = w_rx;
            ram_in_en = 1'b1;
            ram_we    = 1'b1;
            done      = 1'b1;
          end
          default: ;
        endcase
      end
      S_T3: begin
        if (w_alu) begin
          gout     = 1'b1;
          w_rin_en = 1'b1; w_rin_sel = w_rx;
          done     = 1'b1;
        end
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  dec3to8 u_rin_dec (
    .i_sel (w_rin_sel),
    .i_en  (w_rin_en),
    .o_hot (rin)
  );

  dec3to8 u_rout_dec (
    .i_sel (w_rout_sel),
    .i_en  (w_rout_en),
    .o_hot (rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios then random run/rst/instr,
// each cycle compared against a trace-table model of the instruction set.
module tb_control_sequencer;

  typedef struct packed {
    logic [7:0]  rin;
    logic [7:0]  rout;
    logic        cen;
    logic [15:0] cval;
    logic        ain, addsub, xorc, gout, pc_in, pc_out, pc_inc, addr_in;
    logic        ram_oe, ram_ie, ram_we, ir_in, done, halted, illegal;
  } out_t;

  localparam int M_IDLE = 0;
  localparam int M_EXEC = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] instr = '0;
  logic [7:0]  rin, rout;
  logic        ctrl_out_en;
  logic [15:0] ctrl_output;
  logic        ain, addsub, xor_ctrl, gout, pc_in, pc_out, pc_inc, addr_in;
  logic        ram_out_en, ram_in_en, ram_we, ir_in, done, halted, illegal;

  int n_tot = 0;
  int n_bad = 0;
  int m_md  = M_IDLE;
  int m_st  = 0;
  int halt_cnt = 0;

  out_t dut_o;
  assign dut_o = {rin, rout, ctrl_out_en, ctrl_output, ain, addsub, xor_ctrl,
                  gout, pc_in, pc_out, pc_inc, addr_in, ram_out_en, ram_in_en,
                  ram_we, ir_in, done, halted, illegal};

  control_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr),
    .rin(rin), .rout(rout), .ctrl_out_en(ctrl_out_en), .ctrl_output(ctrl_output),
    .ain(ain), .addsub(addsub), .xor_ctrl(xor_ctrl), .gout(gout),
    .pc_in(pc_in), .pc_out(pc_out), .pc_inc(pc_inc), .addr_in(addr_in),
    .ram_out_en(ram_out_en), .ram_in_en(ram_in_en), .ram_we(ram_we),
    .ir_in(ir_in), .done(done), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Total cycles for an instruction, fetch/decode included.
  function automatic int lat(input logic [15:0] ins);
    int op = int'(ins[15:12]);
    if (op >= 3 && op <= 5) return 6;
    if (op == 6 || op == 7) return 5;
    return 4;
  endfunction

  // Expected outputs for cycle st of an instruction (0=fetch addr, 1=fetch
  // data, 2=decode, 3..=execute steps from the opcode action table).
  function automatic out_t trace(input int st, input logic [15:0] ins);
    out_t o = '0;
    int op = int'(ins[15:12]);
    int rx = int'(ins[11:9]);
    int ry = int'(ins[8:6]);
    int t  = st - 3;
    if (st == 0) begin o.pc_out = 1; o.addr_in = 1; end
    else if (st == 1) begin o.ram_oe = 1; o.ir_in = 1; o.pc_inc = 1; end
    else if (st >= 3) begin
      case (op)
        0: o.done = 1;
        1: begin o.rout[ry] = 1; o.rin[rx] = 1; o.done = 1; end
        2: begin o.cen = 1; o.cval = {7'b0, ins[8:0]}; o.rin[rx] = 1; o.done = 1; end
        3, 4, 5: begin
          if (t == 0) begin o.rout[rx] = 1; o.ain = 1; end
          else if (t == 1) begin o.rout[ry] = 1; o.addsub = (op == 4); o.xorc = (op == 5); end
          else begin o.gout = 1; o.rin[rx] = 1; o.done = 1; end
        end
        6: begin
          if (t == 0) begin o.rout[ry] = 1; o.addr_in = 1; end
          else begin o.ram_oe = 1; o.rin[rx] = 1; o.done = 1; end
        end
        7: begin
          if (t == 0) begin o.rout[ry] = 1; o.addr_in = 1; end
          else begin o.rout[rx] = 1; o.ram_ie = 1; o.ram_we = 1; o.done = 1; end
        end
        8: begin o.rout[rx] = 1; o.pc_in = 1; o.done = 1; end
        9: o.done = 1;
        default: begin o.illegal = 1; o.done = 1; end
      endcase
    end
    return o;
  endfunction

  // Apply inputs, advance the model over one edge, then check the DUT.
  task automatic tick(input logic r, input logic rn, input logic [15:0] ins);
    out_t e;
    rst = r; run = rn; instr = ins;
    if (r) begin m_md = M_IDLE; m_st = 0; end
    else if (m_md == M_IDLE) begin
      if (rn) begin m_md = M_EXEC; m_st = 0; end
    end else if (m_md == M_EXEC) begin
      if (m_st == lat(ins) - 1) begin
        if (ins[15:12] == 4'd9) m_md = M_HALT;
        else if (rn) m_st = 0;
        else m_md = M_IDLE;
      end else m_st++;
    end
    halt_cnt = (m_md == M_HALT) ? halt_cnt + 1 : 0;
    @(posedge clk);
    #1;
    e = '0;
    if (m_md == M_HALT) e.halted = 1;
    else if (m_md == M_EXEC) e = trace(m_st, ins);
    chk("outs", dut_o, e);
    chk("bus1", $countones({rout, gout, ctrl_out_en, pc_out, ram_out_en}) <= 1, 1);
    chk("rin_oh", $onehot0(rin), 1);
    chk("rout_oh", $onehot0(rout), 1);
    chk("pc_excl", pc_in & pc_inc, 0);
    chk("cval0", ctrl_out_en ? 16'h0 : ctrl_output, 0);
  endtask

  initial begin
    logic [15:0] cur;
    // reset state
    tick(1, 0, 16'h0);
    chk("rst_zero", dut_o, 0);

    // MVI r2,#5: result in fourth cycle
    repeat (4) tick(0, 1, 16'h2405);
    chk("mvi_cen", ctrl_out_en, 1);
    chk("mvi_val", ctrl_output, 16'h0005);
    chk("mvi_rin", rin, 8'h04);
    chk("mvi_done", done, 1);
    tick(0, 0, 16'h2405);
    chk("mvi_idle", dut_o, 0);

    // ADD r1,r1: done in sixth cycle
    repeat (6) tick(0, 1, 16'h3240);
    chk("add_gout", gout, 1);
    chk("add_rin", rin, 8'h02);
    chk("add_done", done, 1);
    tick(0, 0, 16'h3240);

    // ST rx=1, ry=2
    repeat (4) tick(0, 1, 16'h7280);
    chk("st_t1_rout", rout, 8'h04);
    chk("st_t1_addr", addr_in, 1);
    tick(0, 1, 16'h7280);
    chk("st_t2_rout", rout, 8'h02);
    chk("st_t2_we", {ram_in_en, ram_we, done}, 3'b111);

    // Illegal opcode, then refetch with run high
    tick(0, 1, 16'h7280);
    repeat (3) tick(0, 1, 16'hF000);
    chk("ill_pulse", {illegal, done}, 2'b11);
    tick(0, 1, 16'hF000);
    chk("ill_refetch", {pc_out, illegal, done}, 3'b100);
    // run drops mid-instruction: completes, then idles
    repeat (3) tick(0, 0, 16'hF000);
    chk("nabort_done", done, 1);
    tick(0, 0, 16'hF000);
    chk("nabort_idle", dut_o, 0);

    // Reset during SUB T2
    repeat (5) tick(0, 1, 16'h4240);
    chk("sub_t2", {addsub, xor_ctrl}, 2'b10);
    tick(1, 1, 16'h4240);
    chk("sub_rst", dut_o, 0);
    tick(0, 0, 16'h4240);

    // HALT persists through run toggling; reset releases
    repeat (5) tick(0, 1, 16'h9000);
    for (int i = 0; i < 4; i++) begin
      tick(0, i[0], 16'h9000);
      chk("halt_hold", halted, 1);
    end
    tick(1, 1, 16'h9000);
    chk("halt_rst", {halted, done}, 2'b00);

    // Random traffic
    cur = 16'h0;
    for (int c = 0; c < 4000; c++) begin
      logic r, rn;
      if (m_md != M_EXEC || m_st == 0) cur = 16'($urandom);
      rn = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 63) == 0) || (m_md == M_HALT && halt_cnt > 3);
      tick(r, rn, cur);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
